// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared types and constants for the pipe_mem_sys memory subsystem
//
// Purpose: DM FSM state encoding, legal ranges for the latency/wait-state
// parameters, sticky error flag bit positions, and an index-width helper.
package pipe_mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dm_state_t;

  localparam int IM_LAT_MIN  = 1;
  localparam int IM_LAT_MAX  = 4;
  localparam int DM_WAIT_MAX = 7;
  localparam int DM_CNT_W    = 3;

  localparam int ERR_OOR  = 0;
  localparam int ERR_BUSY = 1;
  localparam int ERR_W    = 2;

  // Array index width for a memory of 'depth' words (at least one bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// rtl/mem_lat_pipe.sv - valid+data shift pipeline of programmable depth
//
// Purpose: delays a valid/data pair by DEPTH clock edges. Data stages only
// load when the incoming valid is set, so o_data holds the last delivered word.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   i_vld     : input valid
//   i_data    : input data
//   o_vld     : valid DEPTH edges after i_vld
//   o_data    : last delivered data word
module mem_lat_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) r_dat[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_dat[DEPTH-1];

endmodule

// File: rtl/pipe_mem_sys.sv
// rtl/pipe_mem_sys.sv - instruction/data memory subsystem for the 16-bit pipelined processor
//
// Purpose: IM with IM_LAT-cycle pipelined reads, DM with DM_WAIT wait states
// and a busy handshake, out-of-range detection and a preload write port.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   im_rd, im_addr                   : IM read request
//   im_r_data, im_valid              : IM read result
//   dm_rd, dm_wr, dm_addr, dm_w_data : DM request
//   dm_r_data, dm_valid, dm_busy     : DM result and handshake
//   load_en, load_sel, load_addr, load_data : preload (load_sel 0=IM, 1=DM)
//   err_oor, err_busy                : sticky error flags
module pipe_mem_sys
  import pipe_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int IM_DEPTH   = 256,
  parameter int DM_DEPTH   = 256,
  parameter int IM_LAT     = 1,
  parameter int DM_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  im_rd,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_r_data,
  output logic                  im_valid,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  dm_valid,
  output logic                  dm_busy,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  err_oor,
  output logic                  err_busy
);

  localparam int IM_LAT_C  = (IM_LAT < IM_LAT_MIN) ? IM_LAT_MIN :
                             ((IM_LAT > IM_LAT_MAX) ? IM_LAT_MAX : IM_LAT);
  localparam int DM_WAIT_C = (DM_WAIT < 0) ? 0 :
                             ((DM_WAIT > DM_WAIT_MAX) ? DM_WAIT_MAX : DM_WAIT);
  localparam bit NO_WAIT   = (DM_WAIT_C == 0);
  localparam int IM_IW     = idx_w(IM_DEPTH);
  localparam int DM_IW     = idx_w(DM_DEPTH);

  localparam logic [ADDR_WIDTH:0]   IM_LIM   = (ADDR_WIDTH+1)'(IM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DM_LIM   = (ADDR_WIDTH+1)'(DM_DEPTH);
  localparam logic [DM_CNT_W-1:0]   CNT_ONE  = DM_CNT_W'(1);
  localparam logic [DM_CNT_W-1:0]   CNT_LOAD = DM_CNT_W'(DM_WAIT_C);

  logic [DATA_WIDTH-1:0] r_im [IM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dm [DM_DEPTH];

  dm_state_t             r_state;
  dm_state_t             w_state_nxt;
  logic [DM_CNT_W-1:0]   r_cnt;
  logic                  r_op_rd;
  logic                  r_op_wr;
  logic [ADDR_WIDTH-1:0] r_op_addr;
  logic [DATA_WIDTH-1:0] r_op_wdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic                  r_dm_valid;
  logic [ERR_W-1:0]      r_err;

  logic                  w_im_oor;
  logic [DATA_WIDTH-1:0] w_im_rdata;
  logic                  w_ld_oor;
  logic                  w_dm_req;
  logic                  w_dm_req_oor;
  logic                  w_accept;
  logic                  w_do;
  logic                  w_op_rd;
  logic                  w_op_wr;
  logic [ADDR_WIDTH-1:0] w_op_addr;
  logic [DATA_WIDTH-1:0] w_op_wdata;
  logic                  w_op_oor;
  logic [DATA_WIDTH-1:0] w_dm_rdata;

  // IM: read at the sampling edge, then delayed through the latency pipe.
  assign w_im_oor   = {1'b0, im_addr} >= IM_LIM;
  assign w_im_rdata = w_im_oor ? '0 : r_im[im_addr[IM_IW-1:0]];

  mem_lat_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (IM_LAT_C)
  ) u_im_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (im_rd),
    .i_data (w_im_rdata),
    .o_vld  (im_valid),
    .o_data (im_r_data)
  );

  assign w_ld_oor = {1'b0, load_addr} >= (load_sel ? DM_LIM : IM_LIM);

  // DM: with no wait states the live request is the operation; otherwise the
  // latched one is performed on the last wait edge.
  assign w_dm_req     = dm_rd | dm_wr;
  assign w_dm_req_oor = {1'b0, dm_addr} >= DM_LIM;
  assign w_accept     = (r_state == ST_IDLE) && w_dm_req;

  assign w_op_rd    = NO_WAIT ? dm_rd     : r_op_rd;
  assign w_op_wr    = NO_WAIT ? dm_wr     : r_op_wr;
  assign w_op_addr  = NO_WAIT ? dm_addr   : r_op_addr;
  assign w_op_wdata = NO_WAIT ? dm_w_data : r_op_wdata;

  // Gated by rst so an access in flight at reset never reaches the array.
  assign w_do = rst && (NO_WAIT ? w_accept : ((r_state == ST_WAIT) && (r_cnt == CNT_ONE)));

  assign w_op_oor   = {1'b0, w_op_addr} >= DM_LIM;
  assign w_dm_rdata = w_op_oor ? '0 : r_dm[w_op_addr[DM_IW-1:0]];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_dm_req && !NO_WAIT) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_cnt == CNT_ONE)     w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op_rd    <= 1'b0;
      r_op_wr    <= 1'b0;
      r_op_addr  <= '0;
      r_op_wdata <= '0;
      r_dm_rdata <= '0;
      r_dm_valid <= 1'b0;
      r_err      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !NO_WAIT) begin
        r_cnt      <= CNT_LOAD;
        r_op_rd    <= dm_rd;
        r_op_wr    <= dm_wr;
        r_op_addr  <= dm_addr;
        r_op_wdata <= dm_w_data;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      r_dm_valid <= w_do;
      if (w_do && w_op_rd) r_dm_rdata <= w_dm_rdata;
      if ((w_accept && w_dm_req_oor) || (im_rd && w_im_oor) || (load_en && w_ld_oor))
        r_err[ERR_OOR] <= 1'b1;
      if ((r_state == ST_WAIT) && w_dm_req)
        r_err[ERR_BUSY] <= 1'b1;
    end
  end

  // Arrays are not reset. The DM read above samples before these writes
  // (read-before-write), and the load is written last so it wins a clash.
  always_ff @(posedge clk) begin
    if (load_en && !load_sel && !w_ld_oor)
      r_im[load_addr[IM_IW-1:0]] <= load_data;
    if (w_do && w_op_wr && !w_op_oor)
      r_dm[w_op_addr[DM_IW-1:0]] <= w_op_wdata;
    if (load_en && load_sel && !w_ld_oor)
      r_dm[load_addr[DM_IW-1:0]] <= load_data;
  end

  assign dm_r_data = r_dm_rdata;
  assign dm_valid  = r_dm_valid;
  assign dm_busy   = (r_state == ST_WAIT);
  assign err_oor   = r_err[ERR_OOR];
  assign err_busy  = r_err[ERR_BUSY];

endmodule

// File: tb/tb_pipe_mem_sys.sv
// tb/tb_pipe_mem_sys.sv - directed self-checking bench for pipe_mem_sys
module tb_pipe_mem_sys;

  logic        clk;
  logic        rst;
  logic        im_rd;
  logic [7:0]  im_addr;
  logic        load_en;
  logic        load_sel;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  logic        a_dm_rd, a_dm_wr;
  logic [7:0]  a_dm_addr;
  logic [15:0] a_dm_w_data;
  logic [15:0] a_im_r_data, a_dm_r_data;
  logic        a_im_valid, a_dm_valid, a_dm_busy, a_err_oor, a_err_busy;

  logic        b_dm_rd, b_dm_wr;
  logic [7:0]  b_dm_addr;
  logic [15:0] b_dm_w_data;
  logic [15:0] b_im_r_data, b_dm_r_data;
  logic        b_im_valid, b_dm_valid, b_dm_busy, b_err_oor, b_err_busy;

  int total = 0;
  int bad   = 0;

  // a: legacy timing, full DM; b: IM_LAT=3, DM_WAIT=2, DM_DEPTH=25
  pipe_mem_sys #(.IM_LAT(1), .DM_WAIT(0), .DM_DEPTH(256)) u_a (
    .clk(clk), .rst(rst),
    .im_rd(im_rd), .im_addr(im_addr), .im_r_data(a_im_r_data), .im_valid(a_im_valid),
    .dm_rd(a_dm_rd), .dm_wr(a_dm_wr), .dm_addr(a_dm_addr), .dm_w_data(a_dm_w_data),
    .dm_r_data(a_dm_r_data), .dm_valid(a_dm_valid), .dm_busy(a_dm_busy),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .err_oor(a_err_oor), .err_busy(a_err_busy)
  );

  pipe_mem_sys #(.IM_LAT(3), .DM_WAIT(2), .DM_DEPTH(25)) u_b (
    .clk(clk), .rst(rst),
    .im_rd(im_rd), .im_addr(im_addr), .im_r_data(b_im_r_data), .im_valid(b_im_valid),
    .dm_rd(b_dm_rd), .dm_wr(b_dm_wr), .dm_addr(b_dm_addr), .dm_w_data(b_dm_w_data),
    .dm_r_data(b_dm_r_data), .dm_valid(b_dm_valid), .dm_busy(b_dm_busy),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .err_oor(b_err_oor), .err_busy(b_err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; im_rd = 0; im_addr = 0;
    load_en = 0; load_sel = 0; load_addr = 0; load_data = 0;
    a_dm_rd = 0; a_dm_wr = 0; a_dm_addr = 0; a_dm_w_data = 0;
    b_dm_rd = 0; b_dm_wr = 0; b_dm_addr = 0; b_dm_w_data = 0;
    tick(); tick();

    check("rst_a_im_valid", a_im_valid, 0);
    check("rst_a_im_data",  a_im_r_data, 0);
    check("rst_a_dm_valid", a_dm_valid, 0);
    check("rst_b_im_valid", b_im_valid, 0);
    check("rst_b_dm_busy",  b_dm_busy, 0);
    check("rst_b_dm_data",  b_dm_r_data, 0);
    check("rst_b_err_oor",  b_err_oor, 0);
    check("rst_b_err_busy", b_err_busy, 0);
    rst = 1'b1;

    // preload IM[0..3], DM[1]=7, DM[24]=16'hABCD
    for (int i = 0; i < 4; i++) begin
      load_en = 1; load_sel = 0; load_addr = 8'(i); load_data = 16'(16'h1000 + i);
      tick();
    end
    load_sel = 1; load_addr = 8'd1;  load_data = 16'd7;     tick();
    load_addr = 8'd24; load_data = 16'hABCD; tick();
    load_en = 0;

    // IM stream: addr 0..3 on consecutive cycles
    for (int k = 0; k < 8; k++) begin
      im_rd = (k < 4); im_addr = 8'(k);
      tick();
      check($sformatf("im_a_valid_%0d", k), a_im_valid, (k < 4) ? 16'd1 : 16'd0);
      check($sformatf("im_a_data_%0d", k), a_im_r_data,
            (k < 4) ? 16'(16'h1000 + k) : 16'h1003);
      check($sformatf("im_b_valid_%0d", k), b_im_valid, (k >= 2 && k <= 5) ? 16'd1 : 16'd0);
      check($sformatf("im_b_data_%0d", k), b_im_r_data,
            (k < 2) ? 16'h0000 : ((k <= 5) ? 16'(16'h1000 + k - 2) : 16'h1003));
    end
    im_rd = 0;

    // DM_WAIT=0: read+write same word, read-before-write
    a_dm_rd = 1; a_dm_wr = 1; a_dm_addr = 8'd1; a_dm_w_data = 16'd100;
    tick();
    check("a_rw_old",   a_dm_r_data, 16'd7);
    check("a_rw_valid", a_dm_valid, 1);
    a_dm_wr = 0;
    tick();
    check("a_rd_new", a_dm_r_data, 16'd100);

    // preload beats a dm write to the same DM word
    a_dm_rd = 0; a_dm_wr = 1; a_dm_addr = 8'd9; a_dm_w_data = 16'h1111;
    load_en = 1; load_sel = 1; load_addr = 8'd9; load_data = 16'h2222;
    tick();
    load_en = 0; a_dm_wr = 0; a_dm_rd = 1;
    tick();
    check("a_load_prio", a_dm_r_data, 16'h2222);
    a_dm_rd = 0;
    tick();
    check("a_valid_idle", a_dm_valid, 0);
    check("a_never_busy", a_dm_busy, 0);

    // DM_WAIT=2: write 5 = 50
    b_dm_wr = 1; b_dm_addr = 8'd5; b_dm_w_data = 16'd50;
    tick();
    b_dm_wr = 0;
    check("b_wr_busy1",  b_dm_busy, 1);
    check("b_wr_valid0", b_dm_valid, 0);
    tick();
    check("b_wr_busy2", b_dm_busy, 1);
    tick();
    check("b_wr_done_busy",  b_dm_busy, 0);
    check("b_wr_done_valid", b_dm_valid, 1);
    check("b_wr_keeps_data", b_dm_r_data, 0);
    // read issued in the dm_valid cycle is accepted
    b_dm_rd = 1; b_dm_addr = 8'd5;
    tick();
    b_dm_rd = 0;
    check("b_rd_busy1",  b_dm_busy, 1);
    check("b_rd_valid0", b_dm_valid, 0);
    tick(); tick();
    check("b_rd_valid", b_dm_valid, 1);
    check("b_rd_data",  b_dm_r_data, 16'd50);
    check("b_rd_busy0", b_dm_busy, 0);
    check("b_no_err_busy", b_err_busy, 0);

    // request while busy is dropped; in-flight read of boundary word 24
    b_dm_rd = 1; b_dm_addr = 8'd24;
    tick();
    b_dm_addr = 8'd30;
    tick();
    b_dm_rd = 0;
    check("b_err_busy", b_err_busy, 1);
    check("b_drop_no_oor", b_err_oor, 0);
    tick();
    check("b_inflight_valid", b_dm_valid, 1);
    check("b_inflight_data",  b_dm_r_data, 16'hABCD);
    tick();
    check("b_dropped_valid", b_dm_valid, 0);
    check("b_dropped_busy",  b_dm_busy, 0);

    // out-of-range read on 25-word DM
    b_dm_rd = 1; b_dm_addr = 8'd30;
    tick();
    b_dm_rd = 0;
    check("b_oor_flag", b_err_oor, 1);
    tick(); tick();
    check("b_oor_valid", b_dm_valid, 1);
    check("b_oor_data",  b_dm_r_data, 0);
    check("a_no_oor", a_err_oor, 0);

    // reset in the middle of a pending write
    b_dm_wr = 1; b_dm_addr = 8'd5; b_dm_w_data = 16'd77;
    tick();
    b_dm_wr = 0;
    check("b_pend_busy", b_dm_busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_b_busy",  b_dm_busy, 0);
    check("mid_rst_b_ebusy", b_err_busy, 0);
    check("mid_rst_b_eoor",  b_err_oor, 0);
    check("mid_rst_b_dmdat", b_dm_r_data, 0);
    check("mid_rst_a_imdat", a_im_r_data, 0);
    check("mid_rst_a_dmdat", a_dm_r_data, 0);
    tick(); tick();
    rst = 1'b1;
    b_dm_rd = 1; b_dm_addr = 8'd5;
    tick();
    b_dm_rd = 0;
    tick(); tick();
    check("post_rst_valid", b_dm_valid, 1);
    check("post_rst_data",  b_dm_r_data, 16'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mem_sys.md
Name: pipe_mem_sys

Overview:
Parametrised instruction/data memory subsystem for the 16-bit pipelined processor. It replaces the fixed one-cycle IM/DM bench models with a synthesizable block. It adds configurable IM read latency, DM wait states with a busy handshake, out-of-range detection, and a preload port. It sits between pipelinedPS (im_*/dm_* ports) and the bench or FPGA top.

Parameters:
DATA_WIDTH, 16, word width of both memories
ADDR_WIDTH, 8, address width of both ports
IM_DEPTH, 256, IM words implemented (1..2^ADDR_WIDTH)
DM_DEPTH, 256, DM words implemented (1..2^ADDR_WIDTH)
IM_LAT, 1, IM read latency in cycles (1..4)
DM_WAIT, 0, DM wait states per access (0..7)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
im_rd  input  1  IM read enable
im_addr  input  ADDR_WIDTH  IM read address
im_r_data  output  DATA_WIDTH  IM read data
im_valid  output  1  im_r_data updated this cycle
dm_rd  input  1  DM read enable
dm_wr  input  1  DM write enable
dm_addr  input  ADDR_WIDTH  DM address
dm_w_data  input  DATA_WIDTH  DM write data
dm_r_data  output  DATA_WIDTH  DM read data
dm_valid  output  1  one-cycle pulse, DM access completed
dm_busy  output  1  DM access in progress, new requests not accepted
load_en  input  1  preload write strobe
load_sel  input  1  0 = IM, 1 = DM
load_addr  input  ADDR_WIDTH  preload address
load_data  input  DATA_WIDTH  preload data
err_oor  output  1  sticky: out-of-range access seen
err_busy  output  1  sticky: DM request dropped while busy

Behaviour:
- Reset (rst=0, async): all outputs 0; IM pipeline flushed; DM FSM to IDLE. Memory arrays are not reset.
- IM path: request sampled when im_rd=1.
  - im_r_data/im_valid are updated IM_LAT edges later.
  - A new request is accepted every cycle (fully pipelined).
  - im_r_data holds its last value when no read completes. im_valid is 0 in those cycles.
  - IM_LAT=1 is cycle-identical to the legacy model.
- DM FSM states: IDLE, WAIT.
  - DM_WAIT=0: no WAIT state. Read data appears on dm_r_data after the sampling edge. A write commits at the sampling edge. dm_valid pulses the cycle after the request. dm_busy is never 1.
  - DM_WAIT=N>0, IDLE: dm_rd|dm_wr is sampled, and op/addr/w_data are latched. The FSM goes to WAIT and a counter is loaded with N. dm_busy=1 from the next cycle.
  - DM_WAIT=N>0, WAIT: the counter decrements each edge. At 0 the op is performed, dm_r_data is updated (reads only), dm_valid pulses for 1 cycle, dm_busy drops, and the FSM returns to IDLE. A request can be accepted in the cycle dm_valid is high.
- Request during WAIT: ignored and err_busy set. In-flight access unaffected.
- dm_rd and dm_wr together: both performed, read-before-write; dm_r_data returns the old word.
- Read address equal to a write committing the same edge (back-to-back): the read sees the new data.
- Out-of-range (addr >= depth):
  - A read returns 0 and still produces valid.
  - A write is dropped.
  - err_oor is set. This also applies to load_addr.
- Preload: load_en writes load_data at the edge.
  - It has priority over a dm write committing the same edge to the same DM; the dm write is dropped with no flag.
  - Loads do not affect the FSM or pipelines.
- Sticky errors clear only on reset.
- Reset mid-access: the access is abandoned and a pending write is not committed.

Decomposition:
- Shared package (pipe_mem_pkg): DM FSM state encoding, IM_LAT/DM_WAIT limit constants, and the err flag bit indices.
- One sub-module, mem_lat_pipe: a valid+data shift pipeline of programmable depth, used for the IM path.

Test Plan:
- IM_LAT=1, preload IM[0..3]=16'h1000..16'h1003; im_rd=1 with addr 0..3 on consecutive cycles -> im_r_data 16'h1000..16'h1003 one cycle after each request, im_valid high 4 cycles.
- IM_LAT=3, same stream -> identical data, each word 3 cycles after its request. No bubbles between words.
- DM_WAIT=2: write addr 5 = 16'd50, then read addr 5 -> dm_busy high 2 cycles per access, dm_valid pulses twice, dm_r_data=16'd50.
- DM_WAIT=2: dm_rd asserted during busy -> request dropped, err_busy=1, in-flight result still correct.
- DM_WAIT=0: dm_rd=dm_wr=1 at addr 1 (old 16'd7, new 16'd100) -> dm_r_data=16'd7, then a read of addr 1 returns 16'd100.
- DM_DEPTH=25: read addr 30 -> dm_r_data=0, dm_valid=1, err_oor=1. Assert rst=0 mid-WAIT -> all outputs 0 immediately, pending write not committed.
